l2k_ptw: RTL and testbench

//  Limn2600 two-level page-table walker; the producer side of the MMU TLB-entry write port.
//  On a TLB miss it reads the PDE and PTE from memory, builds the 64-bit TLB entry and issues
//  one write command to l2k_mmu. Faults are reported to the core and no entry is written.

---
 rtl/l2k_ptw.sv | 177 +++++++++++++++++
 tb/tb_l2k_ptw.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2k_ptw.sv
// Limn2600 two-level page-table walker: fetches PDE then PTE on a TLB miss and
// emits a single TLB write command, or a fault pulse when the walk cannot complete.
module l2k_ptw #(
    parameter logic [1:0] CMD_WRITE = 2'd0,
    parameter logic [1:0] CMD_NOP   = 2'd3,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [31:0] miss_vaddr,
    input  logic [11:0] miss_asid,
    input  logic        miss_store,
    input  logic [31:0] pgtb,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  tlb_cmd,
    output logic [31:0] tlb_entry_addr,
    output logic [63:0] tlb_entry,
    output logic        done,
    output logic        fault,
    output logic [2:0]  fault_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PDE   = 3'd1;
    localparam logic [2:0] S_PTE   = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [2:0] F_PDE_INV = 3'd1;
    localparam logic [2:0] F_PTE_INV = 3'd2;
    localparam logic [2:0] F_BUS     = 3'd3;
    localparam logic [2:0] F_RO      = 3'd4;
    localparam logic [2:0] F_TMO     = 3'd5;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   va_q, va_d;
    logic [11:0]   asid_q, asid_d;
    logic          store_q, store_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    tlb_cmd_q, tlb_cmd_d;
    logic [31:0]   tlb_entry_addr_q, tlb_entry_addr_d;
    logic [63:0]   tlb_entry_q, tlb_entry_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [2:0]    fault_code_q, fault_code_d;
    logic          abort;
    logic [2:0]    abort_code;

    logic unused_pgtb;
    assign unused_pgtb = ^pgtb[11:0];

    always_comb begin
        state_d          = state_q;
        va_d             = va_q;
        asid_d           = asid_q;
        store_d          = store_q;
        mem_req_d        = mem_req_q;
        mem_addr_d       = mem_addr_q;
        tmo_d            = tmo_q;
        tlb_cmd_d        = CMD_NOP;
        tlb_entry_addr_d = tlb_entry_addr_q;
        tlb_entry_d      = tlb_entry_q;
        done_d           = 1'b0;
        fault_d          = 1'b0;
        fault_code_d     = 3'd0;
        abort            = 1'b0;
        abort_code       = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
                    state_d    = S_PDE;
                    va_d       = miss_vaddr;
                    asid_d     = miss_asid;
                    store_d    = miss_store;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pgtb[31:12], miss_vaddr[31:22], 2'b00};
                    tmo_d      = '0;
                end
            end
            S_PDE, S_PTE: begin
                // err takes priority over a same-cycle ack; ack beats the timeout
                if (mem_err) begin
                    abort      = 1'b1;
                    abort_code = F_BUS;
                end else if (mem_ack) begin
                    if (!mem_rdata[0]) begin
                        abort      = 1'b1;
                        abort_code = (state_q == S_PDE) ? F_PDE_INV : F_PTE_INV;
                    end else if (state_q == S_PDE) begin
                        state_d    = S_PTE;
                        mem_addr_d = {mem_rdata[24:5], va_q[21:12], 2'b00};
                        tmo_d      = '0;
                    end else if (store_q && !mem_rdata[1]) begin
                        abort      = 1'b1;
                        abort_code = F_RO;
                    end else begin
                        state_d          = S_FILL;
                        mem_req_d        = 1'b0;
                        tlb_cmd_d        = CMD_WRITE;
                        tlb_entry_addr_d = va_q;
                        tlb_entry_d      = {va_q[31:12], asid_q, mem_rdata};
                        done_d           = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort      = 1'b1;
                    abort_code = F_TMO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FILL, S_FAULT: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_FAULT;
            mem_req_d    = 1'b0;
            fault_d      = 1'b1;
            fault_code_d = abort_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            va_q             <= '0;
            asid_q           <= '0;
            store_q          <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            tmo_q            <= '0;
            tlb_cmd_q        <= CMD_NOP;
            tlb_entry_addr_q <= '0;
            tlb_entry_q      <= '0;
            done_q           <= 1'b0;
            fault_q          <= 1'b0;
            fault_code_q     <= 3'd0;
        end else begin
            state_q          <= state_d;
            va_q             <= va_d;
            asid_q           <= asid_d;
            store_q          <= store_d;
            mem_req_q        <= mem_req_d;
            mem_addr_q       <= mem_addr_d;
            tmo_q            <= tmo_d;
            tlb_cmd_q        <= tlb_cmd_d;
            tlb_entry_addr_q <= tlb_entry_addr_d;
            tlb_entry_q      <= tlb_entry_d;
            done_q           <= done_d;
            fault_q          <= fault_d;
            fault_code_q     <= fault_code_d;
        end
    end

    assign miss_ready     = (state_q == S_IDLE) && !rst;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign tlb_cmd        = tlb_cmd_q;
    assign tlb_entry_addr = tlb_entry_addr_q;
    assign tlb_entry      = tlb_entry_q;
    assign done           = done_q;
    assign fault          = fault_q;
    assign fault_code     = fault_code_q;

endmodule

// File: tb/tb_l2k_ptw.sv
// Bench for l2k_ptw: table of directed walks against a small memory responder,
// plus reset and reset-during-walk sequences.
module tb_l2k_ptw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_vaddr = '0;
    logic [11:0] miss_asid = '0;
    logic        miss_store = 1'b0;
    logic [31:0] pgtb = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic [1:0]  tlb_cmd;
    logic [31:0] tlb_entry_addr;
    logic [63:0] tlb_entry;
    logic        done;
    logic        fault;
    logic [2:0]  fault_code;

    l2k_ptw dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vaddr(miss_vaddr),
        .miss_asid(miss_asid), .miss_store(miss_store), .pgtb(pgtb),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_err(mem_err),
        .mem_rdata(mem_rdata), .tlb_cmd(tlb_cmd), .tlb_entry_addr(tlb_entry_addr),
        .tlb_entry(tlb_entry), .done(done), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] va;
        logic [11:0] asid;
        logic        store;
        logic [31:0] pgtb;
        logic [31:0] pde_a;
        logic [31:0] pde;
        logic [31:0] pte_a;
        logic [31:0] pte;
        int          wait_n;
        int          err_sel;    // 0 none, 1 err on PDE read, 2 err on PTE read
        bit          no_ack;
        logic [2:0]  exp_code;   // 0 = walk completes
        int          exp_lat;    // cycle of done/fault after accept
        int          exp_reqs;
        int          exp_reqcyc;
        logic [63:0] exp_entry;
    } vec_t;

    vec_t vecs[11];

    // responder configuration (written by the test only)
    logic [31:0] pde_a = '0, pde_v = '0, pte_a = '0, pte_v = '0;
    int wait_n = 0, err_sel = 0, force_ack_cyc = -1;
    bit no_ack = 1'b0;

    // monitor / responder state (written by the responder only)
    int done_tot = 0, fault_tot = 0, evt_tot = 0, evt_cyc = 0, write_tot = 0;
    int req_tot = 0, reqcyc_tot = 0, unstable_tot = 0, bad_tot = 0, rcnt = 0;
    logic [2:0]  last_code = '0;
    logic [31:0] prev_addr = '0;

    int n_cmp = 0, n_bad = 0;
    logic [63:0] last_entry = '0;
    logic [31:0] last_eaddr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (done) begin done_tot++; evt_tot++; evt_cyc = cyc; end
            if (fault) begin fault_tot++; evt_tot++; evt_cyc = cyc; last_code = fault_code; end
            if (tlb_cmd == 2'd0) write_tot++;
            if (mem_req) reqcyc_tot++;
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                if (rcnt != 0 && mem_addr != prev_addr) unstable_tot++;
                if (rcnt == 0) req_tot++;
                rcnt++;
                prev_addr = mem_addr;
                if (!no_ack && rcnt == 2 + wait_n) begin
                    rcnt = 0;
                    mem_ack = 1'b1;
                    if (mem_addr == pde_a) begin
                        mem_rdata = pde_v;
                        if (err_sel == 1) mem_err = 1'b1;
                    end else if (mem_addr == pte_a) begin
                        mem_rdata = pte_v;
                        if (err_sel == 2) mem_err = 1'b1;
                    end else begin
                        bad_tot++;
                    end
                end
            end else begin
                rcnt = 0;
            end
            if (cyc == force_ack_cyc) begin mem_ack = 1'b1; mem_rdata = pte_v; end
        end
    end

    task automatic run_vec(input int i);
        vec_t v = vecs[i];
        int d0, f0, e0, w0, r0, rc0, u0, b0, acc;
        bit got;
        @(posedge clk);
        d0 = done_tot; f0 = fault_tot; e0 = evt_tot; w0 = write_tot;
        r0 = req_tot; rc0 = reqcyc_tot; u0 = unstable_tot; b0 = bad_tot;
        @(negedge clk);
        pde_a = v.pde_a; pde_v = v.pde; pte_a = v.pte_a; pte_v = v.pte;
        wait_n = v.wait_n; err_sel = v.err_sel; no_ack = v.no_ack;
        miss_vaddr = v.va; miss_asid = v.asid; miss_store = v.store; pgtb = v.pgtb;
        miss_valid = 1'b1;
        acc = cyc;
        chk($sformatf("v%0d ready_at_accept", i), 64'(miss_ready), 64'd1);
        @(negedge clk);
        miss_valid = 1'b0;
        chk($sformatf("v%0d busy_after_accept", i), 64'(miss_ready), 64'd0);
        got = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            if (evt_tot != e0) begin got = 1'b1; break; end
        end
        chk($sformatf("v%0d walk_ended", i), 64'(got), 64'd1);
        @(negedge clk);
        chk($sformatf("v%0d ready_after", i), 64'(miss_ready), 64'd1);
        chk($sformatf("v%0d req_low_after", i), 64'(mem_req), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk($sformatf("v%0d done_pulses", i), 64'(done_tot - d0), (v.exp_code == 0) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d fault_pulses", i), 64'(fault_tot - f0), (v.exp_code == 0) ? 64'd0 : 64'd1);
        if (v.exp_code != 0) chk($sformatf("v%0d fault_code", i), 64'(last_code), 64'(v.exp_code));
        chk($sformatf("v%0d latency", i), 64'(evt_cyc - acc), 64'(v.exp_lat));
        chk($sformatf("v%0d mem_reqs", i), 64'(req_tot - r0), 64'(v.exp_reqs));
        chk($sformatf("v%0d req_cycles", i), 64'(reqcyc_tot - rc0), 64'(v.exp_reqcyc));
        chk($sformatf("v%0d write_cycles", i), 64'(write_tot - w0), (v.exp_code == 0) ? 64'd1 : 64'd0);
        chk($sformatf("v%0d addr_unstable", i), 64'(unstable_tot - u0), 64'd0);
        chk($sformatf("v%0d addr_wrong", i), 64'(bad_tot - b0), 64'd0);
        if (v.exp_code == 0) begin last_entry = v.exp_entry; last_eaddr = v.va; end
        chk($sformatf("v%0d tlb_entry", i), tlb_entry, last_entry);
        chk($sformatf("v%0d tlb_entry_addr", i), 64'(tlb_entry_addr), 64'(last_eaddr));
        chk($sformatf("v%0d tlb_cmd_idle", i), 64'(tlb_cmd), 64'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, f0, w0, acc;
        //                 va            asid    st    pgtb          pde_a         pde           pte_a         pte          wt  err noack code lat  rq  rqc  entry
        vecs[0]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E03, 0,   0, 1'b0, 3'd0, 5,   2, 4,   64'h4030_55A7_0000_0E03};
        vecs[1]  = '{32'hFFC0_1ABC, 12'hFFF, 1'b1, 32'hABCD_E123, 32'hABCD_EFFC, 32'h0246_8AC1, 32'h2345_6004, 32'hFFFF_FFFF, 0,   0, 1'b0, 3'd0, 5,   2, 4,   64'hFFC0_1FFF_FFFF_FFFF};
        vecs[2]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0400, 32'h0002_0C14, 32'h0000_0E03, 0,   0, 1'b0, 3'd1, 3,   1, 2,   64'h0};
        vecs[3]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E02, 0,   0, 1'b0, 3'd2, 5,   2, 4,   64'h0};
        vecs[4]  = '{32'h4030_5123, 12'h5A7, 1'b1, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E01, 0,   0, 1'b0, 3'd4, 5,   2, 4,   64'h0};
        vecs[5]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E01, 0,   0, 1'b0, 3'd0, 5,   2, 4,   64'h4030_55A7_0000_0E01};
        vecs[6]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E03, 0,   2, 1'b0, 3'd3, 5,   2, 4,   64'h0};
        vecs[7]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E03, 0,   1, 1'b0, 3'd3, 3,   1, 2,   64'h0};
        vecs[8]  = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E03, 0,   0, 1'b1, 3'd5, 256, 1, 255, 64'h0};
        vecs[9]  = '{32'h4030_5123, 12'h001, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E03, 7,   0, 1'b0, 3'd0, 19,  2, 18,  64'h4030_5001_0000_0E03};
        vecs[10] = '{32'h4030_5123, 12'h5A7, 1'b0, 32'h0010_0000, 32'h0010_0400, 32'h0000_0401, 32'h0002_0C14, 32'h0000_0E03, 253, 0, 1'b0, 3'd0, 511, 2, 510, 64'h4030_55A7_0000_0E03};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst miss_ready", 64'(miss_ready), 64'd0);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst tlb_cmd", 64'(tlb_cmd), 64'd3);
        chk("rst tlb_entry", tlb_entry, 64'd0);
        chk("rst tlb_entry_addr", 64'(tlb_entry_addr), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst fault", 64'(fault), 64'd0);
        chk("rst fault_code", 64'(fault_code), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle miss_ready", 64'(miss_ready), 64'd1);

        for (int i = 0; i < 11; i++) run_vec(i);

        // reset while the PTE read is pending; an ack then arrives one cycle late
        @(posedge clk);
        d0 = done_tot; f0 = fault_tot; w0 = write_tot;
        @(negedge clk);
        pde_a = vecs[0].pde_a; pde_v = vecs[0].pde; pte_a = vecs[0].pte_a; pte_v = vecs[0].pte;
        wait_n = 0; err_sel = 0; no_ack = 1'b0;
        miss_vaddr = vecs[0].va; miss_asid = vecs[0].asid; miss_store = 1'b0; pgtb = vecs[0].pgtb;
        miss_valid = 1'b1;
        acc = cyc;
        force_ack_cyc = acc + 4;
        @(negedge clk);
        miss_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstwalk pte_addr", 64'(mem_addr), 64'(vecs[0].pte_a));
        chk("rstwalk pte_req", 64'(mem_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwalk req_dropped", 64'(mem_req), 64'd0);
        chk("rstwalk ready_in_rst", 64'(miss_ready), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstwalk ready", 64'(miss_ready), 64'd1);
        chk("rstwalk req_low", 64'(mem_req), 64'd0);
        @(posedge clk);
        chk("rstwalk no_done", 64'(done_tot - d0), 64'd0);
        chk("rstwalk no_fault", 64'(fault_tot - f0), 64'd0);
        chk("rstwalk no_write", 64'(write_tot - w0), 64'd0);
        chk("rstwalk entry_cleared", tlb_entry, 64'd0);
        force_ack_cyc = -1;
        last_entry = '0;
        last_eaddr = '0;

        // walker recovers after the mid-walk reset
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
